// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions.
//   HOR_PIXELS / VER_PIXELS : active display size
//   rgb_t                   : 12-bit colour (4:4:4)
//   coord_t                 : 11-bit screen coordinate
//   TRANSPARENT_DEFAULT     : default colour key for sprite stages
//   vga_bus_t               : packed copy of the vga_if fields, used by delay lines
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    typedef logic [11:0] rgb_t;
    typedef logic [10:0] coord_t;

    localparam rgb_t TRANSPARENT_DEFAULT = 12'h000;

    typedef struct packed {
        coord_t hcount;
        coord_t vcount;
        logic   hsync;
        logic   vsync;
        logic   hblnk;
        logic   vblnk;
        rgb_t   rgb;
    } vga_bus_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed along the draw-stage chain.
//   vga_in  modport : consumer side (all inputs)
//   vga_out modport : producer side (all outputs)
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_delay.sv
// DEPTH-stage shift register for the VGA bus plus a 1-bit sideband.
//   clk      : pixel clock
//   rst      : synchronous active-high reset, clears every stage
//   din      : VGA fields in
//   side_in  : sideband bit travelling with the pixel
//   dout     : VGA fields, DEPTH cycles later
//   side_out : sideband bit, DEPTH cycles later
module vga_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  vga_bus_t din,
    input  logic     side_in,
    output vga_bus_t dout,
    output logic     side_out
);

    vga_bus_t stage [DEPTH];
    logic     side  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
                side[i]  <= 1'b0;
            end
        end else begin
            stage[0] <= din;
            side[0]  <= side_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
                side[i]  <= side[i-1];
            end
        end
    end

    assign dout     = stage[DEPTH-1];
    assign side_out = side[DEPTH-1];

endmodule

// File: rtl/draw_player_sprite.sv
// Player sprite overlay stage: position, horizontal flip, animation frames
// from one ROM, colour-key transparency, configurable ROM latency.
//   clk, rst         : pixel clock, synchronous active-high reset
//   pos_x, pos_y     : sprite top-left corner (latched at vblank start)
//   flip, hide       : mirror / suppress (latched at vblank start)
//   anim_en          : advance the animation on vblank starts
//   rom_addr         : registered sprite ROM address
//   rom_rgb          : ROM data, ROM_LATENCY cycles after rom_addr
//   frame_idx        : current animation frame
//   vga_in / vga_out : upstream / downstream VGA bus
module draw_player_sprite
    import vga_pkg::*;
#(
    parameter int   SPRITE_W     = 140,
    parameter int   SPRITE_H     = 177,
    parameter int   FRAMES       = 4,
    parameter int   FRAME_PERIOD = 8,
    parameter int   ROM_LATENCY  = 1,
    parameter int   ADDR_W       = 17,
    parameter rgb_t TRANSPARENT  = TRANSPARENT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  logic              flip,
    input  logic              anim_en,
    input  logic              hide,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic [2:0]        frame_idx,
    vga_if.vga_in             vga_in,
    vga_if.vga_out            vga_out
);

    localparam int L  = 1 + ROM_LATENCY;
    localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPRITE_W);
    localparam logic [7:0]        LAST_COL   = 8'(SPRITE_W - 1);
    localparam logic [11:0]       W12        = 12'(SPRITE_W);
    localparam logic [11:0]       H12        = 12'(SPRITE_H);

    coord_t          sx, sy;
    logic            flip_q, hide_q;
    logic            vblnk_prev, vblnk_rise;
    logic [PW-1:0]   period_cnt;

    logic [11:0]       h12, v12, sx12, sy12;
    logic              inside_c, inside_d;
    logic [7:0]        rel_x, rel_y, col;
    logic [ADDR_W-1:0] addr_c;
    vga_bus_t          bus_in, bus_d;

    assign vblnk_rise = vga_in.vblnk && !vblnk_prev;

    // Shadow registers and animation only move at vblank start, so the
    // sprite never tears or changes frame mid-picture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            sx         <= '0;
            sy         <= '0;
            flip_q     <= 1'b0;
            hide_q     <= 1'b1;
            period_cnt <= '0;
            frame_idx  <= '0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (vblnk_rise) begin
                sx     <= pos_x;
                sy     <= pos_y;
                flip_q <= flip;
                hide_q <= hide;
                if (anim_en) begin
                    if (period_cnt == PW'(FRAME_PERIOD - 1)) begin
                        period_cnt <= '0;
                        frame_idx  <= (frame_idx == 3'(FRAMES - 1)) ? '0 : frame_idx + 3'd1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // 12-bit bounds so a sprite hanging off the right/bottom edge clips
    // instead of wrapping back to column/row 0.
    always_comb begin
        h12      = {1'b0, vga_in.hcount};
        v12      = {1'b0, vga_in.vcount};
        sx12     = {1'b0, sx};
        sy12     = {1'b0, sy};
        inside_c = (h12 >= sx12) && (h12 < sx12 + W12) &&
                   (v12 >= sy12) && (v12 < sy12 + H12) &&
                   !vga_in.hblnk && !vga_in.vblnk && !hide_q;
        rel_x    = 8'(vga_in.hcount - sx);
        rel_y    = 8'(vga_in.vcount - sy);
        col      = flip_q ? LAST_COL - rel_x : rel_x;
        addr_c   = ADDR_W'(frame_idx) * FRAME_SIZE + ADDR_W'(rel_y) * ROW_SIZE + ADDR_W'(col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= inside_c ? addr_c : '0;
        end
    end

    always_comb begin
        bus_in.hcount = vga_in.hcount;
        bus_in.vcount = vga_in.vcount;
        bus_in.hsync  = vga_in.hsync;
        bus_in.vsync  = vga_in.vsync;
        bus_in.hblnk  = vga_in.hblnk;
        bus_in.vblnk  = vga_in.vblnk;
        bus_in.rgb    = vga_in.rgb;
    end

    // The inside flag enters the delay line unregistered; its first stage
    // is the stage-A register, keeping it aligned with rom_rgb at depth L.
    vga_delay #(.DEPTH(L)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .din      (bus_in),
        .side_in  (inside_c),
        .dout     (bus_d),
        .side_out (inside_d)
    );

    always_comb begin
        vga_out.hcount = bus_d.hcount;
        vga_out.vcount = bus_d.vcount;
        vga_out.hsync  = bus_d.hsync;
        vga_out.vsync  = bus_d.vsync;
        vga_out.hblnk  = bus_d.hblnk;
        vga_out.vblnk  = bus_d.vblnk;
        vga_out.rgb    = (!inside_d || rom_rgb == TRANSPARENT) ? bus_d.rgb : rom_rgb;
    end

endmodule

// File: tb/tb_draw_player_sprite.sv
module tb_draw_player_sprite;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [10:0] pos_x = 11'd0, pos_y = 11'd0;
    logic        flip = 1'b0, anim_en = 1'b0, hide = 1'b1;
    logic [16:0] addr1, addr3;
    logic [11:0] rom1, r3a, r3b, r3c;
    logic [2:0]  fr1, fr3;

    vga_if vin();
    vga_if vo1();
    vga_if vo3();

    draw_player_sprite #(.FRAME_PERIOD(2), .ROM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
        .anim_en(anim_en), .hide(hide), .rom_addr(addr1), .rom_rgb(rom1),
        .frame_idx(fr1), .vga_in(vin), .vga_out(vo1));

    draw_player_sprite #(.FRAME_PERIOD(2), .ROM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
        .anim_en(anim_en), .hide(hide), .rom_addr(addr3), .rom_rgb(r3c),
        .frame_idx(fr3), .vga_in(vin), .vga_out(vo3));

    // ROM image: every word is F0F except address 5, which holds the key colour.
    function automatic rgb_t rom_f(input logic [16:0] a);
        return (a == 17'd5) ? 12'h000 : 12'hF0F;
    endfunction

    always @(posedge clk) begin
        rom1 <= rom_f(addr1);
        r3a  <= rom_f(addr3);
        r3b  <= r3a;
        r3c  <= r3b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        rgb_t   rgb;
        coord_t h, v;
        logic   hs, vs, hb, vb;
        string  nm;
    } vexp_t;

    typedef struct {
        int          due;
        logic        chk_a;
        logic [16:0] addr;
        logic [2:0]  frame;
        string       nm;
    } cexp_t;

    vexp_t qv1[$], qv3[$];
    cexp_t qc1[$], qc3[$];
    int checks = 0, failures = 0;
    logic [2:0] exp_frame = 3'd0;

    task automatic check_v(input string tag, input vexp_t e, input rgb_t rgb, input coord_t h, v,
                           input logic hs, vs, hb, vb);
        checks++;
        if (e.due != cyc || {rgb, h, v, hs, vs, hb, vb} !== {e.rgb, e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
            failures++;
            $display("FAIL %s %s @cyc%0d: got rgb=%h h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b want rgb=%h h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                     tag, e.nm, cyc, rgb, h, v, hs, vs, hb, vb, e.rgb, e.h, e.v, e.hs, e.vs, e.hb, e.vb);
        end
    endtask

    task automatic check_c(input string tag, input cexp_t e, input logic [16:0] a, input logic [2:0] f);
        checks++;
        if (e.due != cyc || f !== e.frame || (e.chk_a && a !== e.addr)) begin
            failures++;
            $display("FAIL %s %s @cyc%0d: got rom_addr=%0d frame_idx=%0d want rom_addr=%0d(chk=%b) frame_idx=%0d",
                     tag, e.nm, cyc, a, f, e.addr, e.chk_a, e.frame);
        end
    endtask

    // Monitor: pops every expectation whose output is due this cycle.
    always @(negedge clk) begin
        vexp_t ve;
        cexp_t ce;
        while (qv1.size() > 0 && qv1[0].due <= cyc) begin
            ve = qv1.pop_front();
            check_v("L2_vga", ve, vo1.rgb, vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk);
        end
        while (qv3.size() > 0 && qv3[0].due <= cyc) begin
            ve = qv3.pop_front();
            check_v("L4_vga", ve, vo3.rgb, vo3.hcount, vo3.vcount, vo3.hsync, vo3.vsync, vo3.hblnk, vo3.vblnk);
        end
        while (qc1.size() > 0 && qc1[0].due <= cyc) begin
            ce = qc1.pop_front();
            check_c("L2_ctl", ce, addr1, fr1);
        end
        while (qc3.size() > 0 && qc3[0].due <= cyc) begin
            ce = qc3.pop_front();
            check_c("L4_ctl", ce, addr3, fr3);
        end
    end

    task automatic drive(input coord_t h, v, input logic hb, vb, input rgb_t rgb_in,
                         input bit pv, input rgb_t exp_rgb,
                         input bit pc, input bit ca, input logic [16:0] ea, input string nm);
        vexp_t ve;
        cexp_t ce;
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[2];
        vin.vsync  = v[1];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb_in;
        if (pv) begin
            ve.rgb = exp_rgb; ve.h = h; ve.v = v; ve.hs = h[2]; ve.vs = v[1];
            ve.hb = hb; ve.vb = vb; ve.nm = nm;
            ve.due = cyc + 2; qv1.push_back(ve);
            ve.due = cyc + 4; qv3.push_back(ve);
        end
        if (pc) begin
            ce.due = cyc + 1; ce.chk_a = ca; ce.addr = ea; ce.frame = exp_frame; ce.nm = nm;
            qc1.push_back(ce);
            qc3.push_back(ce);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input coord_t h, v, input rgb_t in, exp, input logic [16:0] ea, input string nm);
        drive(h, v, 1'b0, 1'b0, in, 1'b1, exp, 1'b1, 1'b1, ea, nm);
    endtask

    task automatic vedge();
        drive(11'd0, 11'd770, 1'b1, 1'b1, 12'h5A5, 1'b1, 12'h5A5, 1'b0, 1'b0, '0, "vblank0");
        drive(11'd4, 11'd771, 1'b1, 1'b1, 12'hA5A, 1'b1, 12'hA5A, 1'b0, 1'b0, '0, "vblank1");
        drive(11'd8, 11'd0,   1'b1, 1'b0, 12'h3C3, 1'b1, 12'h3C3, 1'b0, 1'b0, '0, "hblank");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(11'd0, 11'd0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, '0, "idle");
    endtask

    task automatic rst_cycles(input int n);
        vexp_t ve;
        cexp_t ce;
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            vin.hcount = 11'd1000; vin.vcount = 11'd430; vin.hsync = 1'b1; vin.vsync = 1'b1;
            vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hFFF;
            ve.due = cyc + 1; ve.rgb = '0; ve.h = '0; ve.v = '0; ve.hs = 1'b0; ve.vs = 1'b0;
            ve.hb = 1'b0; ve.vb = 1'b0; ve.nm = "reset";
            qv1.push_back(ve);
            qv3.push_back(ve);
            ce.due = cyc + 1; ce.chk_a = 1'b1; ce.addr = '0; ce.frame = 3'd0; ce.nm = "reset";
            qc1.push_back(ce);
            qc3.push_back(ce);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    logic [2:0]  frame_seq [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
    logic [16:0] addr_seq  [9] = '{17'd139, 17'd0, 17'd24780, 17'd24780, 17'd49560,
                                   17'd49560, 17'd74340, 17'd74340, 17'd0};

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        @(posedge clk);
        #1;
        rst_cycles(3);

        // Basic placement at (880,430): sprite spans x 880..1019, y 430..606.
        pos_x = 11'd880; pos_y = 11'd430; hide = 1'b0; flip = 1'b0;
        vedge();
        pix(11'd880,  11'd430, 12'h123, 12'hF0F, 17'd0,     "tl_corner");
        pix(11'd1019, 11'd606, 12'h456, 12'hF0F, 17'd24779, "br_corner");
        pix(11'd879,  11'd430, 12'h789, 12'h789, 17'd0,     "left_of");
        pix(11'd1020, 11'd430, 12'hABC, 12'hABC, 17'd0,     "right_of");
        pix(11'd880,  11'd429, 12'h111, 12'h111, 17'd0,     "above");
        pix(11'd880,  11'd607, 12'h222, 12'h222, 17'd0,     "below");
        pix(11'd885,  11'd430, 12'h333, 12'h333, 17'd5,     "transparent");
        drive(11'd900, 11'd500, 1'b1, 1'b0, 12'h444, 1'b1, 12'h444, 1'b1, 1'b1, 17'd0, "in_hblank");

        // Horizontal flip.
        flip = 1'b1;
        vedge();
        pix(11'd880,  11'd430, 12'h555, 12'hF0F, 17'd139, "flip_left");
        pix(11'd1019, 11'd430, 12'h666, 12'hF0F, 17'd0,   "flip_right");
        pix(11'd1014, 11'd430, 12'h777, 12'h777, 17'd5,   "flip_transp");

        // Animation, frame_idx sampled before each of 9 vblank edges.
        anim_en = 1'b1;
        flip = 1'b0;
        for (int e = 0; e < 9; e++) begin
            exp_frame = frame_seq[e];
            pix(11'd880, 11'd430, 12'h0A0, 12'hF0F, addr_seq[e], "anim");
            vedge();
        end
        anim_en = 1'b0;
        exp_frame = 3'd0;

        // Position change mid-frame takes effect only at the next vblank edge.
        pos_x = 11'd100;
        pix(11'd880, 11'd431, 12'h0B0, 12'hF0F, 17'd140, "old_pos_kept");
        pix(11'd100, 11'd431, 12'h0C0, 12'h0C0, 17'd0,   "new_pos_early");
        vedge();
        pix(11'd100, 11'd431, 12'h0D0, 12'hF0F, 17'd140,   "new_pos");
        pix(11'd880, 11'd431, 12'h0E0, 12'h0E0, 17'd0,     "old_pos_gone");
        pix(11'd239, 11'd606, 12'h0F0, 12'hF0F, 17'd24779, "new_br");
        pix(11'd240, 11'd430, 12'h101, 12'h101, 17'd0,     "new_right_of");

        // Right-edge clipping with no wrap to low columns.
        pos_x = 11'd1000;
        vedge();
        pix(11'd1000, 11'd430, 12'h202, 12'hF0F, 17'd0,  "clip_left");
        pix(11'd1023, 11'd430, 12'h303, 12'hF0F, 17'd23, "clip_last");
        drive(11'd1100, 11'd430, 1'b1, 1'b0, 12'h404, 1'b1, 12'h404, 1'b1, 1'b1, 17'd0, "clip_blank");
        pix(11'd50,  11'd430, 12'h505, 12'h505, 17'd0, "no_wrap50");
        pix(11'd119, 11'd430, 12'h606, 12'h606, 17'd0, "no_wrap119");

        // Reset mid-line: outputs zero, sprite hidden until the next vblank edge.
        idle(5);
        rst_cycles(3);
        pix(11'd1000, 11'd430, 12'h707, 12'h707, 17'd0, "hidden_after_rst");
        pix(11'd1010, 11'd431, 12'h808, 12'h808, 17'd0, "hidden_after_rst2");
        vedge();
        pix(11'd1000, 11'd430, 12'h909, 12'hF0F, 17'd0, "shown_after_edge");
        pix(11'd1005, 11'd430, 12'hA0A, 12'hA0A, 17'd5, "transp_after_edge");

        idle(6);
        checks++;
        if (qv1.size() + qv3.size() + qc1.size() + qc3.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0",
                     qv1.size() + qv3.size() + qc1.size() + qc3.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_player_sprite.md
Name: draw_player_sprite

Overview:
Parametrised sprite overlay stage for the VGA pipeline. It replaces fixed-position, single-image player drawers, and one instance is used per player. Features: runtime position, horizontal flip, multi-frame animation from a single ROM, configurable transparent key, and configurable ROM read latency with timing signals kept aligned. It sits between background/earlier draw stages and later overlay stages on the vga_if chain.

Parameters:
SPRITE_W, 140, sprite width in pixels (1..255)
SPRITE_H, 177, sprite height in pixels (1..255)
FRAMES, 4, animation frames stored back-to-back in ROM (1..8)
FRAME_PERIOD, 8, video frames per animation step (>=1)
ROM_LATENCY, 1, cycles from rom_addr to valid rom_rgb (1..3)
ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPRITE_W*SPRITE_H
TRANSPARENT, 12'h000, colour key that is never drawn

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
pos_x  in  11  requested sprite left edge, screen coordinates
pos_y  in  11  requested sprite top edge
flip  in  1  1 = mirror horizontally
anim_en  in  1  1 = advance animation
hide  in  1  1 = sprite not drawn
rom_addr  out  ADDR_W  registered ROM read address
rom_rgb  in  12  ROM data, valid ROM_LATENCY cycles after rom_addr
frame_idx  out  3  current animation frame
vga_in  vga_if.vga_in  -  upstream timing and rgb
vga_out  vga_if.vga_out  -  downstream timing and rgb

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: all vga_out fields 0, rom_addr 0, frame_idx 0, shadow pos 0/0, flip 0, hide 1, anim counters 0.
- Shadow registers: pos_x/pos_y/flip/hide are sampled only on the rising edge of vga_in.vblnk (registered previous value 0, current 1). This gives tear-free updates. Between edges, input changes have no effect.
- Stage A, registered:
  - inside = (hcount >= sx) && (hcount < sx+SPRITE_W) && (vcount >= sy) && (vcount < sy+SPRITE_H) && !hblnk && !vblnk && !hide_q.
  - Comparisons use 12-bit sums, so sx+SPRITE_W > 2047 does not wrap. Sprites running past the active area are clipped naturally.
- Address:
  - rel_x = hcount-sx and rel_y = vcount-sy, each 8 bits.
  - col = flip_q ? SPRITE_W-1-rel_x : rel_x.
  - rom_addr = frame_idx*SPRITE_W*SPRITE_H + rel_y*SPRITE_W + col, computed at ADDR_W width.
  - When !inside, rom_addr = 0.
- Delay line: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb and inside are delayed by L = 1+ROM_LATENCY cycles from vga_in. Every vga_out timing field equals the vga_in field L cycles earlier.
- Output: vga_out.rgb = rgb_d when !inside_d or rom_rgb == TRANSPARENT; otherwise rom_rgb. vga_out.rgb is combinational from the delayed registers and rom_rgb.
- Animation:
  - period counter 0..FRAME_PERIOD-1 increments on each vblnk rising edge while anim_en=1.
  - On wrap, frame_idx <= (frame_idx == FRAMES-1) ? 0 : frame_idx+1.
  - anim_en=0 holds both the counter and frame_idx; it does not reset them.
  - frame_idx changes only at the vblnk edge, so it never changes mid-frame.
- FRAMES=1: frame_idx is constant 0.
- Reset mid-frame: the delay line is cleared. Outputs track the input L cycles after rst deasserts. The sprite stays hidden until the first vblnk edge, where the shadow registers load.

Decomposition:
- vga_pkg: existing HOR_PIXELS/VER_PIXELS constants. Add a 12-bit colour typedef, the 11-bit coordinate typedef and TRANSPARENT_DEFAULT.
- Sub-module vga_delay (DEPTH parameter): shift register for the vga_if fields plus a 1-bit sideband. It is reused by other overlay stages.

Test Plan:
- Reset, then pos=(880,430), hide=0, one vblnk edge, ROM model returns 12'hF0F inside. Check pixel (880,430) and (1019,606) output F0F; (879,430) and (1020,430) pass through rgb_in; latency L=2 for ROM_LATENCY=1.
- flip=1 latched. Check that at hcount=880 rom_addr = 139 (frame 0, row 0) and at hcount=1019 rom_addr = 0.
- ROM returns 12'h000 at an inside pixel -> output equals delayed vga_in.rgb.
- anim_en=1, FRAME_PERIOD=2, FRAMES=4. Check frame_idx sequence 0,0,1,1,2,2,3,3,0 across 9 vblnk edges. Check first-row rom_addr at frame 1 = 24780.
- Change pos_x from 880 to 100 mid-active-frame -> sprite stays at 880 until the next vblnk rising edge, then moves to 100. pos_x=1000 -> right part clipped, no wrap to hcount 0..119.
- Assert rst for 3 cycles mid-line -> all outputs 0 during reset, sprite hidden until the next vblnk edge. Rerun with ROM_LATENCY=3 and check L=4 alignment.
